// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch front-end.
// Defaults assume a 50 MHz clock, 20 ms debounce and 100 Hz count tick.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int CLK_HZ  = 50_000_000;
  localparam int DEB_MS  = 20;
  localparam int TICK_HZ = 100;

  localparam int DEF_DIV        = CLK_HZ / TICK_HZ;
  localparam int DEF_DEB_CYCLES = (CLK_HZ / 1000) * DEB_MS;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch front-end.
// The controller uses the slave view; whatever drives the buttons uses master.
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_clear;
  logic tick;
  logic stop;
  logic clear;
  logic running;

  modport master (output btn_start, btn_clear, input tick, stop, clear, running);
  modport slave  (input btn_start, btn_clear, output tick, stop, clear, running);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, mismatch-count debouncer and rising-edge detector.
// press is a single-cycle pulse one cycle after the debounced level rises.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          press_q, press_d;

  // NOTE: every signal gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    cnt_d        = '0;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) stable_d = sync2_q;
      else                              cnt_d    = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with <= so every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle controller with debounced buttons and a divided count tick
// that feeds the BCD stopwatch counter; all outputs come straight from flops.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  stopwatch_ctrl_if.slave  sw
);

  localparam int PW = cnt_width(DIV);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          stop_q, stop_d;
  logic          clear_q, clear_d;
  logic          running_q, running_d;
  logic          start_press, clear_press;
  logic          advance;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clock(clock), .reset_n(reset_n), .raw(sw.btn_start), .press(start_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clock(clock), .reset_n(reset_n), .raw(sw.btn_clear), .press(clear_press)
  );

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_press)      clear_d = 1'b1;
        else if (start_press) state_d = RUN;
      end
      // Start has priority in RUN; clear is not honoured while counting.
      RUN: begin
        if (start_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (clear_press) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (start_press) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The prescaler only advances on edges that stay in RUN, so pausing freezes
  // the partial period and no tick can coincide with stop going high.
  always_comb begin
    advance   = (state_q == RUN) && (state_d == RUN);
    pre_d     = pre_q;
    tick_d    = 1'b0;
    running_d = (state_d == RUN);
    stop_d    = (state_d != RUN);
    if (state_d == IDLE) begin
      pre_d = '0;
    end else if (advance) begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      stop_q    <= 1'b1;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      stop_q    <= stop_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign sw.tick    = tick_q;
  assign sw.stop    = stop_q;
  assign sw.clear   = clear_q;
  assign sw.running = running_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Front-end control stage that sits directly upstream of the 4-digit BCD stopwatch counter/display block.
- Synchronises and debounces two raw push-buttons (start/stop, clear) and runs a run/pause/idle state machine.
- Generates a divided single-cycle count tick, plus the stop level and clear pulse that the counter consumes.

Parameters:
- DIV, 500000, clock cycles per count tick (100 Hz at 50 MHz); minimum 2
- DEB_CYCLES, 1000000, cycles a synchronised button level must stay constant before it is accepted (20 ms at 50 MHz); minimum 1

Ports:
- clock  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous active-low reset
- btn_start  in  1  raw start/stop button, asynchronous, 1 = pressed
- btn_clear  in  1  raw clear button, asynchronous, 1 = pressed
- tick  out  1  one-cycle count enable to the counter, only while running
- stop  out  1  1 = counter must hold; drives the counter's stop input
- clear  out  1  one-cycle pulse, counter must load 0000
- running  out  1  1 while in RUN, for status LED

Behaviour:
- Clocking and reset: one clock, clock. reset_n is synchronous and active-low, sampled only on posedge clock.
- Reset values while reset_n=0 at an edge:
  - state=IDLE, tick=0, stop=1, clear=0, running=0
  - prescaler=0, synchronisers=0, debounce counters=0, stable levels=0
- Synchroniser: each button passes through 2 flip-flops.
- Debounce, per button:
  - If synced != stable, the counter increments; if synced == stable, the counter clears to 0.
  - When the counter reaches DEB_CYCLES-1 while still mismatched, stable takes synced and the counter clears.
  - press = registered rising edge of stable, one cycle wide.
- Latency: a raw 0->1 held steady produces press exactly DEB_CYCLES+3 cycles after the first sampling edge. Releases produce no press.
- Glitch rejection: a pulse shorter than DEB_CYCLES synced cycles never changes stable.
- FSM states: IDLE (stopped, counter zeroed), RUN, PAUSE.
  - IDLE: start_press -> RUN; clear_press -> IDLE with clear pulse.
  - RUN: start_press -> PAUSE; clear_press is ignored.
  - PAUSE: start_press -> RUN; clear_press -> IDLE with clear pulse.
- Simultaneous start_press and clear_press in the same cycle:
  - In RUN, start wins (-> PAUSE), clear is ignored.
  - In IDLE or PAUSE, clear wins (-> IDLE with clear pulse), start is ignored.
- Outputs are registered and reflect the new state on the edge following the press pulse.
  - stop = (state != RUN); running = (state == RUN).
  - clear is high exactly one cycle.
- Prescaler, width clog2(DIV):
  - Increments only in RUN and wraps DIV-1 -> 0.
  - tick=1 for the single cycle in which the prescaler wraps.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Forced to 0 on entry to IDLE.
- Tick timing: first tick after IDLE->RUN occurs DIV cycles after running rises. No tick is ever asserted while stop=1.
- Reset mid-run: next edge with reset_n=0 gives tick=0, stop=1, and discards any pending press.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE} (2 bits)
  - default constants CLK_HZ=50_000_000, DEB_MS=20, TICK_HZ=100
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clock, reset_n, raw, press) holds the synchroniser, debounce counter and edge detect. It is instantiated twice.

Test Plan (DIV=4, DEB_CYCLES=3 unless stated):
- Reset: hold reset_n=0 for 3 cycles with buttons toggling -> stop=1, tick=0, clear=0, running=0 throughout and one cycle after release.
- Start: btn_start 0->1 held 10 cycles -> press at cycle 6, running=1/stop=0 at cycle 7; tick pulses at cycles 11, 15, 19 (period 4, width 1).
- Glitch: btn_start high for 2 cycles only -> no state change, no tick, stable stays 0.
- Pause/resume: in RUN with prescaler=2, press start -> PAUSE (stop=1, no tick); press start again -> first tick 2 cycles after running rises.
- Clear rules: clear press in RUN -> ignored, no clear pulse. Clear press in PAUSE -> exactly one clear cycle, state IDLE, prescaler 0.
- Simultaneous: both buttons pressed together in RUN -> PAUSE, clear=0. Repeat in PAUSE -> IDLE with clear=1 for one cycle.
